// File: rtl/accum_seq_ctrl.sv
// Start/accumulate/commit sequencer for the shared accumulate-and-commit datapath.
// Sums NUM_BEATS data beats, then publishes the sum on commit with a one-cycle done pulse.
module accum_seq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int NUM_BEATS = 2,
  parameter int MAX_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic              commit,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              overflow
);

  localparam int BW = $clog2(NUM_BEATS + 1);
  localparam int GW = $clog2(MAX_GAP + 2);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [GW-1:0] GAP_LIM   = GW'(MAX_GAP);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACC         = 2'd1,
    WAIT_COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [BW-1:0]     beat_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              ovf_acc;
  logic [DATA_W:0]   sum_ext;

  // Wrapping add; the extra top bit is the carry-out used for overflow tracking.
  function automatic logic [DATA_W:0] add_wrap(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sum_ext = add_wrap(acc, data_in);
  assign busy    = (state == ACC) || (state == WAIT_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      ovf_acc  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      abort    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !hold) begin
            state    <= ACC;
            acc      <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            ovf_acc  <= 1'b0;
          end
        end
        ACC: begin
          if (data_vld) begin
            acc      <= sum_ext[DATA_W-1:0];
            ovf_acc  <= ovf_acc | sum_ext[DATA_W];
            beat_cnt <= beat_cnt + 1'b1;
            gap_cnt  <= '0;
            if (beat_cnt == LAST_BEAT) state <= WAIT_COMMIT;
          end else if (beat_cnt != '0) begin
            // Bubbles only count once the first beat has arrived.
            if (gap_cnt == GAP_LIM) begin
              abort <= 1'b1;
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        WAIT_COMMIT: begin
          if (commit) begin
            data_out <= acc;
            overflow <= ovf_acc;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
